// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel timer: FSM states, register
// offsets inside a channel window, CTRL bit positions and mode codes.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    // Word offsets within one channel's four-register window
    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    // CTRL register bit positions
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    // MODE codes; the two remaining codes behave as one-shot
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: CTRL/PRESET/COUNT/STATUS registers and the
// IDLE/LOAD/CNT/INT down-counter FSM. Raises irq when pending and unmasked.
module timer_channel
    import timer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  offset,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    logic             en;
    logic [1:0]       mode;
    logic             im;
    logic [WIDTH-1:0] preset;
    logic [WIDTH-1:0] count;
    logic             pend;
    state_t           state;

    // Upper data bits beyond WIDTH are deliberately dropped on writes.
    logic unused_din;
    assign unused_din = ^din;

    // Register writes and counter FSM; statement order sets the priorities.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments; when several
        // assignments hit the same register in one edge, the last one wins.
        if (!reset) begin
            en     <= 1'b0;
            mode   <= MODE_ONESHOT;
            im     <= 1'b0;
            preset <= '0;
            count  <= '0;
            pend   <= 1'b0;
            state  <= ST_IDLE;
        end else begin
            // W1C comes first so a same-edge set from INT overrides it.
            if (we && offset == OFF_STATUS && din[0]) begin
                pend <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (en) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    count <= preset;
                    state <= ST_CNT;
                end
                ST_CNT: begin
                    if (!en) begin
                        state <= ST_IDLE;
                    end else if (count > WIDTH'(1)) begin
                        count <= count - WIDTH'(1);
                    end else begin
                        // Covers both 1 -> 0 and an immediate expiry from 0.
                        count <= '0;
                        state <= ST_INT;
                    end
                end
                ST_INT: begin
                    pend <= 1'b1;
                    if (mode == MODE_RELOAD) begin
                        state <= ST_LOAD;
                    end else begin
                        en    <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // CPU CTRL write comes last so it beats the one-shot EN clear.
            if (we && offset == OFF_CTRL) begin
                en   <= din[CTRL_EN];
                mode <= din[CTRL_MODE_HI:CTRL_MODE_LO];
                im   <= din[CTRL_IM];
            end
            if (we && offset == OFF_PRESET) begin
                preset <= din[WIDTH-1:0];
            end
        end
    end

    // Zero-extended read-back of the register selected by offset.
    always_comb begin
        // NOTE: default assignment first so no path leaves dout unassigned
        // (which would infer a latch).
        dout = '0;
        case (offset)
            OFF_CTRL:   dout[3:0]       = {im, mode, en};
            OFF_PRESET: dout[WIDTH-1:0] = preset;
            OFF_COUNT:  dout[WIDTH-1:0] = count;
            OFF_STATUS: dout[0]         = pend;
            default:    dout            = '0;
        endcase
    end

    assign irq = pend & im;

endmodule

// File: rtl/timer_array.sv
// N_CH independent timer channels behind one word-addressed window.
// Addr = {channel index, register offset}; unused channel indices read 0.
module timer_array
    import timer_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = $clog2(N_CH) + 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] Addr,
    input  logic              WE,
    input  logic [31:0]       Din,
    output logic [31:0]       Dout,
    output logic [N_CH-1:0]   IRQ,
    output logic              IRQ_any
);

    logic [ADDR_W-1:0] ch_idx;
    logic [31:0]       ch_dout [N_CH];

    assign ch_idx = Addr >> 2;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        timer_channel #(
            .WIDTH (WIDTH)
        ) u_channel (
            .clk    (clk),
            .reset  (reset),
            .offset (Addr[1:0]),
            .we     (WE && (ch_idx == ADDR_W'(i))),
            .din    (Din),
            .dout   (ch_dout[i]),
            .irq    (IRQ[i])
        );
    end

    // Read mux: the addressed channel drives Dout; out-of-range reads give 0.
    always_comb begin
        Dout = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_idx == ADDR_W'(i)) Dout = ch_dout[i];
        end
    end

    assign IRQ_any = |IRQ;

endmodule

// File: tb/tb_timer_array.sv
// Directed bench for timer_array: a default instance (4 ch, 32 bit) and a
// narrow instance (3 ch, 16 bit) sharing clock and reset.
module tb_timer_array;
    import timer_pkg::*;

    logic        clk = 1'b0;
    logic        reset;

    logic [3:0]  a_addr;
    logic        a_we;
    logic [31:0] a_din;
    logic [31:0] a_dout;
    logic [3:0]  a_irq;
    logic        a_irq_any;

    logic [3:0]  b_addr;
    logic        b_we;
    logic [31:0] b_din;
    logic [31:0] b_dout;
    logic [2:0]  b_irq;
    logic        b_irq_any;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    timer_array u_dut_a (
        .clk     (clk),
        .reset   (reset),
        .Addr    (a_addr),
        .WE      (a_we),
        .Din     (a_din),
        .Dout    (a_dout),
        .IRQ     (a_irq),
        .IRQ_any (a_irq_any)
    );

    timer_array #(
        .N_CH  (3),
        .WIDTH (16)
    ) u_dut_b (
        .clk     (clk),
        .reset   (reset),
        .Addr    (b_addr),
        .WE      (b_we),
        .Din     (b_din),
        .Dout    (b_dout),
        .IRQ     (b_irq),
        .IRQ_any (b_irq_any)
    );

    function automatic logic [3:0] ad(input int ch, input logic [1:0] off);
        logic [1:0] c;
        c = 2'(ch);
        return {c, off};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, returning on the following falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle write landing on the next rising edge.
    task automatic wr(input bit sel, input logic [3:0] a, input logic [31:0] d);
        if (sel) begin
            b_addr = a; b_din = d; b_we = 1'b1;
        end else begin
            a_addr = a; a_din = d; a_we = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        a_we = 1'b0;
        b_we = 1'b0;
    endtask

    task automatic rd(input bit sel, input logic [3:0] a, input logic [31:0] exp, input string tag);
        if (sel) b_addr = a;
        else     a_addr = a;
        #1;
        check(tag, sel ? b_dout : a_dout, exp);
    endtask

    initial begin
        // Reset held for two edges while writes of all-ones are attempted
        reset  = 1'b0;
        a_addr = ad(0, OFF_CTRL); a_we = 1'b1; a_din = 32'hFFFF_FFFF;
        b_addr = ad(0, OFF_CTRL); b_we = 1'b1; b_din = 32'hFFFF_FFFF;
        tick(2);
        reset = 1'b1;
        a_we  = 1'b0;
        b_we  = 1'b0;
        for (int ch = 0; ch < 4; ch++) begin
            for (int off = 0; off < 4; off++) begin
                rd(0, ad(ch, 2'(off)), 32'h0, "rst_reg");
            end
            tick(1);
        end
        check("rst_irq", a_irq, 4'b0000);
        check("rst_irq_any", a_irq_any, 1'b0);
        rd(1, ad(0, OFF_CTRL), 32'h0, "rst_b_ctrl");
        rd(1, ad(2, OFF_PRESET), 32'h0, "rst_b_preset");
        check("rst_b_irq", b_irq, 3'b000);

        // One-shot on ch0: PRESET=5, enable with IM at E0
        wr(0, ad(0, OFF_PRESET), 32'd5);
        wr(0, ad(0, OFF_CTRL), 32'h9);
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            rd(0, ad(0, OFF_COUNT), (k >= 2 && k <= 7) ? 32'(7 - k) : 32'd0, "os_count");
            check("os_irq0", a_irq[0], (k == 8));
        end
        rd(0, ad(0, OFF_CTRL), 32'h8, "os_ctrl_after");
        rd(0, ad(0, OFF_STATUS), 32'h1, "os_status");
        wr(0, ad(0, OFF_STATUS), 32'h1);
        check("os_irq0_cleared", a_irq[0], 1'b0);
        check("os_irq_any_cleared", a_irq_any, 1'b0);
        wr(0, ad(0, OFF_COUNT), 32'h55);
        rd(0, ad(0, OFF_COUNT), 32'h0, "count_read_only");

        // Auto-reload on ch1, masked at first: PRESET=3 gives a 5-cycle period
        wr(0, ad(1, OFF_PRESET), 32'd3);
        wr(0, ad(1, OFF_CTRL), 32'h3);
        tick(5);
        rd(0, ad(1, OFF_STATUS), 32'h0, "ar_pend_e5");
        tick(1);
        rd(0, ad(1, OFF_STATUS), 32'h1, "ar_pend_e6");
        check("ar_irq_masked", a_irq[1], 1'b0);
        wr(0, ad(1, OFF_STATUS), 32'h1);
        rd(0, ad(1, OFF_STATUS), 32'h0, "ar_w1c_e7");
        tick(3);
        rd(0, ad(1, OFF_STATUS), 32'h0, "ar_pend_e10");
        rd(0, ad(1, OFF_COUNT), 32'h0, "ar_count_e10");
        tick(1);
        rd(0, ad(1, OFF_STATUS), 32'h1, "ar_pend_e11");
        check("ar_irq_masked_e11", a_irq[1], 1'b0);
        wr(0, ad(1, OFF_CTRL), 32'hB);
        check("ar_irq_unmasked", a_irq[1], 1'b1);
        check("ar_irq_any", a_irq_any, 1'b1);
        rd(0, ad(1, OFF_COUNT), 32'd3, "ar_count_e12");
        wr(0, ad(1, OFF_STATUS), 32'h1);
        check("ar_irq_cleared_e13", a_irq[1], 1'b0);
        rd(0, ad(1, OFF_COUNT), 32'd2, "ar_count_e13");
        tick(2);
        rd(0, ad(1, OFF_COUNT), 32'd0, "ar_count_e15");
        // W1C on the same edge the FSM sets PEND: the set wins
        wr(0, ad(1, OFF_STATUS), 32'h1);
        rd(0, ad(1, OFF_STATUS), 32'h1, "coll_w1c_vs_set");
        check("coll_irq1", a_irq[1], 1'b1);
        // PRESET write on the LOAD edge: this load still uses the old value
        wr(0, ad(1, OFF_PRESET), 32'd7);
        rd(0, ad(1, OFF_COUNT), 32'd3, "coll_preset_old_load");
        rd(0, ad(1, OFF_PRESET), 32'd7, "coll_preset_readback");
        tick(5);
        rd(0, ad(1, OFF_COUNT), 32'd7, "coll_preset_next_load");
        wr(0, ad(1, OFF_CTRL), 32'h0);
        tick(3);
        wr(0, ad(1, OFF_STATUS), 32'h1);
        rd(0, ad(1, OFF_COUNT), 32'd6, "ar_stop_count");
        check("ar_stop_irq_any", a_irq_any, 1'b0);

        // Pause on ch2: disable on the edge that makes COUNT 6, then restart
        wr(0, ad(2, OFF_PRESET), 32'd10);
        wr(0, ad(2, OFF_CTRL), 32'h9);
        tick(5);
        rd(0, ad(2, OFF_COUNT), 32'd7, "pause_count_e5");
        wr(0, ad(2, OFF_CTRL), 32'h0);
        rd(0, ad(2, OFF_COUNT), 32'd6, "pause_count_e6");
        tick(5);
        rd(0, ad(2, OFF_COUNT), 32'd6, "pause_count_held");
        rd(0, ad(2, OFF_STATUS), 32'h0, "pause_no_pend");
        check("pause_no_irq", a_irq[2], 1'b0);
        wr(0, ad(2, OFF_CTRL), 32'h9);
        tick(1);
        rd(0, ad(2, OFF_COUNT), 32'd6, "restart_load_cycle");
        tick(1);
        rd(0, ad(2, OFF_COUNT), 32'd10, "restart_reloaded");
        wr(0, ad(2, OFF_CTRL), 32'h0);
        tick(2);
        check("restart_stop_irq_any", a_irq_any, 1'b0);

        // ch3: CPU CTRL write on the one-shot EN-clear edge keeps EN set
        wr(0, ad(3, OFF_CTRL), 32'h1);
        tick(3);
        rd(0, ad(3, OFF_STATUS), 32'h0, "cpu_win_pend_e3");
        wr(0, ad(3, OFF_CTRL), 32'h1);
        rd(0, ad(3, OFF_CTRL), 32'h1, "cpu_win_ctrl");
        rd(0, ad(3, OFF_STATUS), 32'h1, "cpu_win_pend_e4");
        check("cpu_win_irq_masked", a_irq[3], 1'b0);
        wr(0, ad(3, OFF_CTRL), 32'h0);
        tick(3);
        wr(0, ad(3, OFF_STATUS), 32'h1);
        rd(0, ad(3, OFF_STATUS), 32'h0, "cpu_win_cleared");
        rd(0, ad(0, OFF_CTRL), 32'h8, "indep_ch0_ctrl");

        // Narrow instance: truncation, out-of-range channel, concurrent expiry
        wr(1, ad(0, OFF_PRESET), 32'h12345);
        rd(1, ad(0, OFF_PRESET), 32'h2345, "b_preset_trunc");
        wr(1, ad(3, OFF_PRESET), 32'hAB);
        rd(1, ad(3, OFF_PRESET), 32'h0, "b_oor_preset");
        rd(1, ad(3, OFF_CTRL), 32'h0, "b_oor_ctrl");
        rd(1, ad(1, OFF_PRESET), 32'h0, "b_oor_no_alias1");
        tick(1);
        rd(1, ad(2, OFF_PRESET), 32'h0, "b_oor_no_alias2");
        rd(1, ad(0, OFF_PRESET), 32'h2345, "b_oor_no_alias0");
        wr(1, ad(0, OFF_PRESET), 32'd3);
        wr(1, ad(2, OFF_PRESET), 32'd2);
        wr(1, ad(0, OFF_CTRL), 32'h9);
        wr(1, ad(2, OFF_CTRL), 32'h9);
        tick(4);
        check("b_irq_before", b_irq, 3'b000);
        tick(1);
        check("b_irq_concurrent", b_irq, 3'b101);
        check("b_irq_any", b_irq_any, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
